// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;

  // 33-bit compare so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_in_range(input logic [29:0]   word_addr,
                                         input logic [31:0]   base,
                                         input int unsigned   depth);
    logic [32:0] byte_a;
    logic [32:0] lo;
    logic [32:0] hi;
    byte_a = {1'b0, word_addr, 2'b00};
    lo     = {1'b0, base};
    hi     = lo + 33'(depth) * 33'(WORD_BYTES);
    return (byte_a >= lo) && (byte_a < hi);
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word array with byte-masked synchronous write and a registered synchronous read port.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned depth_words = 1024
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           rd_en_i,
  input  logic [$clog2(depth_words)-1:0] rd_idx_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(depth_words)-1:0] wr_idx_i,
  input  logic [3:0]                     wr_mask_i,
  input  logic [31:0]                    wr_data_i,
  output logic [31:0]                    rd_data_o
);

  logic [31:0] mem_q [depth_words];
  logic [31:0] rd_data_q;

  // NOTE: the storage array has no reset; clearing it would force a flop
  // implementation instead of a RAM, and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_mask_i[i]) begin
          mem_q[wr_idx_i][i*LANE_W +: LANE_W] <= wr_data_i[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mips_data_mem.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait states,
// one-cycle ready pulse, address-window fault reporting.
module mips_data_mem
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] data_start  = 32'h1000_0000,
  parameter int unsigned depth_words = 1024,
  parameter int unsigned wait_states = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_in,
  input  logic [3:0]  mem_write_en,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        mem_excpt,
  output logic        mem_busy
);

  localparam int unsigned AW = $clog2(depth_words);
  localparam int unsigned CW = 4;

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    mask_q;
  logic          write_q;

  logic          accept;
  logic          rd_en;
  logic          wr_en;
  logic          in_range;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [31:0]   rd_data;

  function automatic logic [AW-1:0] word_index(input logic [29:0] word_addr);
    return AW'(word_addr - data_start[31:2]);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_addr;
        data_q  <= mem_data_in;
        mask_q  <= mem_write_en;
        write_q <= |mem_write_en;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|mem_write_en) || mem_req) begin
          accept = 1'b1;
          if (wait_states == 0) begin
            state_d = RESP;
            cnt_d   = '0;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(wait_states) - CW'(1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read is issued one edge before RESP; with no wait states that edge is the accept.
  assign rd_idx   = word_index((state_q == IDLE) ? mem_addr : addr_q);
  assign wr_idx   = word_index(addr_q);
  assign in_range = addr_in_range(addr_q, data_start, depth_words);
  assign wr_en    = (state_q == RESP) && write_q && in_range && rst_b;

  always_comb begin
    mem_ready    = 1'b0;
    mem_excpt    = 1'b0;
    mem_data_out = '0;
    mem_busy     = (state_q != IDLE);
    if (state_q == RESP) begin
      mem_ready = 1'b1;
      mem_excpt = !in_range;
      if (!write_q && in_range) begin
        mem_data_out = rd_data;
      end
    end
  end

  mips_mem_array #(
    .depth_words(depth_words)
  ) u_array (
    .clk       (clk),
    .rst_b     (rst_b),
    .rd_en_i   (rd_en),
    .rd_idx_i  (rd_idx),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_mask_i (mask_q),
    .wr_data_i (data_q),
    .rd_data_o (rd_data)
  );

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array model.
module tb_mips_data_mem;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
  localparam int          WS_A  = 2;
  localparam int          WS_B  = 0;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_s   [2];
  logic [29:0] addr_s  [2];
  logic [31:0] din_s   [2];
  logic [3:0]  we_s    [2];
  logic [31:0] dout_s  [2];
  logic        ready_s [2];
  logic        excpt_s [2];
  logic        busy_s  [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] last_dout;
  int          kidx [2][$];

  always #5 clk = ~clk;

  mips_data_mem #(.data_start(BASE), .depth_words(DEPTH), .wait_states(WS_A)) dut_a (
    .clk(clk), .rst_b(rst_b), .mem_req(req_s[0]), .mem_addr(addr_s[0]),
    .mem_data_in(din_s[0]), .mem_write_en(we_s[0]), .mem_data_out(dout_s[0]),
    .mem_ready(ready_s[0]), .mem_excpt(excpt_s[0]), .mem_busy(busy_s[0])
  );

  mips_data_mem #(.data_start(BASE), .depth_words(DEPTH), .wait_states(WS_B)) dut_b (
    .clk(clk), .rst_b(rst_b), .mem_req(req_s[1]), .mem_addr(addr_s[1]),
    .mem_data_in(din_s[1]), .mem_write_en(we_s[1]), .mem_data_out(dout_s[1]),
    .mem_ready(ready_s[1]), .mem_excpt(excpt_s[1]), .mem_busy(busy_s[1])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? WS_A : WS_B;
  endfunction

  function automatic bit ref_in_range(input logic [31:0] baddr);
    longint b;
    b = longint'(baddr);
    return (b >= longint'(BASE)) && (b < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // One complete transaction; returns at the falling edge inside the ready cycle.
  task automatic run_op(input int d, input logic rq, input logic [31:0] baddr,
                        input logic [31:0] wdata, input logic [3:0] mask, input string tag);
    bit          is_wr, inr, got;
    int          idx, lat;
    logic [31:0] exp_data, m;
    is_wr    = (mask != 4'b0000);
    inr      = ref_in_range(baddr);
    idx      = inr ? int'((baddr - BASE) >> 2) : 0;
    exp_data = 32'h0;
    if (!is_wr && inr) exp_data = model_mem[d][idx];
    @(negedge clk);
    req_s[d]  = rq;
    addr_s[d] = baddr[31:2];
    din_s[d]  = wdata;
    we_s[d]   = mask;
    @(posedge clk);
    #1;
    req_s[d]  = 1'b0;
    we_s[d]   = 4'b0000;
    addr_s[d] = 30'($urandom);
    din_s[d]  = $urandom;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (ready_s[d] === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else begin
        total++;
        if (busy_s[d] !== 1'b1 || excpt_s[d] !== 1'b0 || dout_s[d] !== 32'h0) begin
          bad++;
          $display("FAIL %s wait_cycle%0d: busy=%b excpt=%b data=%h, required busy=1 excpt=0 data=0",
                   tag, k, busy_s[d], excpt_s[d], dout_s[d]);
        end
      end
    end
    total++;
    if (!got || lat != ws_of(d) + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles (0 = none), required %0d", tag, lat, ws_of(d) + 1);
    end
    if (got) begin
      last_dout = dout_s[d];
      total++;
      if (excpt_s[d] !== ~inr) begin
        bad++;
        $display("FAIL %s excpt: got %b, required %b", tag, excpt_s[d], ~inr);
      end
      total++;
      if (dout_s[d] !== exp_data) begin
        bad++;
        $display("FAIL %s data: got %h, required %h", tag, dout_s[d], exp_data);
      end
      total++;
      if (busy_s[d] !== 1'b1) begin
        bad++;
        $display("FAIL %s busy_in_resp: got %b, required 1", tag, busy_s[d]);
      end
    end
    if (is_wr && inr) begin
      m = lane_mask(mask);
      model_mem[d][idx] = (model_mem[d][idx] & ~m) | (wdata & m);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({ready_s[d], excpt_s[d], busy_s[d], dout_s[d]} !== 35'h0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: ready=%b excpt=%b busy=%b data=%h, required all 0",
                 d, ready_s[d], excpt_s[d], busy_s[d], dout_s[d]);
      end
    end
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    run_op(0, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, "wr_full");
    run_op(0, 1'b1, 32'h1000_0010, 32'h0, 4'b0000, "rd_full");
    total++;
    if (last_dout !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rd_full_value: got %h, required deadbeef", last_dout);
    end
    run_op(0, 1'b0, 32'h1000_0010, 32'h0000_00AA, 4'b0001, "wr_lane0");
    run_op(0, 1'b1, 32'h1000_0010, 32'h0, 4'b0000, "rd_lane0");
    total++;
    if (last_dout !== 32'hDEAD_BEAA) begin
      bad++;
      $display("FAIL rd_lane0_value: got %h, required deadbeaa", last_dout);
    end
  endtask

  task automatic test_range();
    run_op(0, 1'b0, 32'h1000_0000, 32'h1111_1111, 4'b1111, "wr_first");
    run_op(0, 1'b0, 32'h1000_0FFC, 32'h2222_2222, 4'b1111, "wr_last");
    run_op(0, 1'b1, 32'h0FFF_FFFC, 32'h0, 4'b0000, "rd_below");
    run_op(0, 1'b1, 32'h1000_1000, 32'h0, 4'b0000, "rd_past_end");
    run_op(0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'b0000, "rd_top");
    run_op(0, 1'b0, 32'h1000_1000, 32'hCAFE_F00D, 4'b1111, "wr_past_end");
    run_op(0, 1'b0, 32'h0FFF_FFFC, 32'hABCD_1234, 4'b1111, "wr_below");
    run_op(0, 1'b1, 32'h1000_0000, 32'h0, 4'b0000, "rd_first");
    total++;
    if (last_dout !== 32'h1111_1111) begin
      bad++;
      $display("FAIL first_word_kept: got %h, required 11111111", last_dout);
    end
    run_op(0, 1'b1, 32'h1000_0FFC, 32'h0, 4'b0000, "rd_last");
    total++;
    if (last_dout !== 32'h2222_2222) begin
      bad++;
      $display("FAIL last_word_kept: got %h, required 22222222", last_dout);
    end
  endtask

  // Request held high: one pulse per transaction, re-accept in the first idle cycle.
  task automatic test_hold();
    bit exp_rdy, exp_busy;
    int n;
    n = 2 * WS_A + 3;
    @(negedge clk);
    req_s[0]  = 1'b1;
    addr_s[0] = 30'h0400_0004;
    we_s[0]   = 4'b0000;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      exp_rdy  = (k == WS_A + 1) || (k == n);
      exp_busy = (k != WS_A + 2);
      total++;
      if (ready_s[0] !== exp_rdy) begin
        bad++;
        $display("FAIL hold_ready cycle%0d: got %b, required %b", k, ready_s[0], exp_rdy);
      end
      total++;
      if (busy_s[0] !== exp_busy) begin
        bad++;
        $display("FAIL hold_busy cycle%0d: got %b, required %b", k, busy_s[0], exp_busy);
      end
      if (k == WS_A + 1) begin
        total++;
        if (dout_s[0] !== 32'hDEAD_BEAA) begin
          bad++;
          $display("FAIL hold_data: got %h, required deadbeaa", dout_s[0]);
        end
      end
    end
    req_s[0] = 1'b0;
    @(negedge clk);
    total++;
    if (ready_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: ready=%b busy=%b, required 0 0", ready_s[0], busy_s[0]);
    end
  endtask

  task automatic test_reset_mid();
    run_op(0, 1'b0, 32'h1000_0020, 32'h5A5A_5A5A, 4'b1111, "wr_prior");
    @(negedge clk);
    we_s[0]   = 4'b1111;
    addr_s[0] = 30'h0400_0008;
    din_s[0]  = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    we_s[0] = 4'b0000;
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready_s[0], excpt_s[0], busy_s[0], dout_s[0]} !== 35'h0) begin
      bad++;
      $display("FAIL midreset_outputs: ready=%b excpt=%b busy=%b data=%h, required all 0",
               ready_s[0], excpt_s[0], busy_s[0], dout_s[0]);
    end
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (ready_s[0] !== 1'b0) begin
        bad++;
        $display("FAIL midreset_no_ready cycle%0d: got %b, required 0", k, ready_s[0]);
      end
    end
    run_op(0, 1'b1, 32'h1000_0020, 32'h0, 4'b0000, "rd_after_abort");
    total++;
    if (last_dout !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL abort_discarded: got %h, required 5a5a5a5a", last_dout);
    end
  endtask

  task automatic test_zero_wait();
    run_op(1, 1'b0, 32'h1000_0100, 32'h1234_5678, 4'b1111, "ws0_wr");
    run_op(1, 1'b1, 32'h1000_0100, 32'h0, 4'b0000, "ws0_rd");
    total++;
    if (last_dout !== 32'h1234_5678) begin
      bad++;
      $display("FAIL ws0_rd_value: got %h, required 12345678", last_dout);
    end
    run_op(1, 1'b1, 32'h1000_0100, 32'hA1B2_C3D4, 4'b1100, "ws0_req_and_mask");
    run_op(1, 1'b1, 32'h1000_0100, 32'h0, 4'b0000, "ws0_rd_upper");
    total++;
    if (last_dout !== 32'hA1B2_5678) begin
      bad++;
      $display("FAIL ws0_write_priority: got %h, required a1b25678", last_dout);
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      run_op(d, 1'b0, 32'h1000_0040, 32'h600D_CAFE, 4'b1111, "b2b_wr");
      run_op(d, 1'b1, 32'h1000_0040, 32'h0, 4'b0000, "b2b_rd");
      total++;
      if (last_dout !== 32'h600D_CAFE) begin
        bad++;
        $display("FAIL b2b_value dut%0d: got %h, required 600dcafe", d, last_dout);
      end
    end
  endtask

  task automatic test_random();
    int          idx;
    logic [31:0] baddr;
    logic [3:0]  mask;
    logic        rq;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        idx = $urandom_range(0, DEPTH - 1);
        kidx[d].push_back(idx);
        run_op(d, 1'b0, BASE + 32'(idx * 4), $urandom, 4'b1111, "rnd_seed");
      end
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 2) begin
          do begin
            case ($urandom_range(0, 2))
              0:       baddr = BASE - 32'(4 * $urandom_range(1, 8));
              1:       baddr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
              default: baddr = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            endcase
          end while (ref_in_range(baddr));
        end else begin
          baddr = BASE + 32'(kidx[d][$urandom_range(0, kidx[d].size() - 1)] * 4);
        end
        mask = 4'($urandom_range(0, 15));
        rq   = 1'($urandom_range(0, 1));
        if (mask == 4'b0000) rq = 1'b1;
        run_op(d, rq, baddr, $urandom, mask, "rnd_op");
      end
    end
  endtask

  initial begin
    rst_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_s[d]  = 1'b0;
      addr_s[d] = '0;
      din_s[d]  = '0;
      we_s[d]   = '0;
    end
    test_reset();
    test_basic();
    test_range();
    test_hold();
    test_reset_mid();
    test_zero_wait();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_data_mem.md
# mips_data_mem

Multi-cycle data-memory responder for the MIPS core's data port. Accepts one read or byte-masked write request at a time and serves it from a word-addressed backing array after a fixed number of wait states. Asserts `mem_excpt` for addresses outside its window. Signals completion with a one-cycle `mem_ready` pulse so the core can stall on it.

## Interface
- `data_start`, 32'h10000000, byte address of word 0; must be word-aligned.
- `depth_words`, 1024, number of 32-bit words held; power of two.
- `wait_states`, 2, number of cycles spent in WAIT; range 0..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_b`  in  1  reset; one clock, reset is synchronous and active-low.
- `mem_req`  in  1  read request valid; sampled only in IDLE.
- `mem_addr`  in  30  word address; byte address is {mem_addr, 2'b00}.
- `mem_data_in`  in  32  store data, byte lanes aligned to address.
- `mem_write_en`  in  4  byte write mask, bit i enables bits [8i+7:8i]; nonzero means write request.
- `mem_data_out`  out  32  read data; valid only while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_excpt`  out  1  address fault; valid only while `mem_ready`=1.
- `mem_busy`  out  1  high in WAIT and RESP; the core must hold off new requests.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: a request is accepted when `|mem_write_en` or `mem_req`. Write takes priority if both are set.
  - On accept, latch addr, data, mask and a write flag.
  - Go to WAIT if `wait_states`>0, else to RESP. Load the wait counter with `wait_states`-1.
- WAIT: decrement the counter each cycle. At 0, go to RESP. All inputs are ignored.
- RESP: assert `mem_ready` for exactly one cycle, then return to IDLE.
  - A request presented in RESP is ignored; it is not queued.
- Range check on the latched address, using a 33-bit compare so there is no wrap-around:
  - In range iff data_start ≤ {addr,2'b00} < data_start + 4·depth_words.
  - Array index = ({addr,2'b00} − data_start) >> 2, width $clog2(depth_words).
- In-range read: `mem_data_out` = stored word in the RESP cycle; `mem_excpt`=0.
- In-range write: masked lanes are committed at the RESP clock edge; unmasked lanes are unchanged. `mem_data_out`=0, `mem_excpt`=0.
- Out-of-range access of either kind: `mem_excpt`=1 and `mem_data_out`=0. A write has no effect on the array.
- A write with mask 4'b0000 is not a request.
- Outside RESP, `mem_data_out`=0, `mem_excpt`=0 and `mem_ready`=0.

## Timing
- Reset (`rst_b`=0 at a rising edge): state=IDLE, counter=0, latches cleared. Outputs `mem_ready`=0, `mem_excpt`=0, `mem_data_out`=0, `mem_busy`=0. Array contents are not cleared.
- Reset mid-operation aborts the transaction. A pending write is discarded and no `mem_ready` is produced.
- Latency: request accepted at edge N, `mem_ready` high during cycle N+wait_states+1.
- Throughput: one request per wait_states+2 cycles.
- Read data is the array value before any write in the same edge. Back-to-back write-then-read of the same word returns the new data.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Package `mips_mem_pkg`:
  - state enum `mem_state_t` {IDLE, WAIT, RESP};
  - lane width constant (8) and word-bytes constant (4).
- Sub-module `mips_mem_array`: `depth_words`×32 array with synchronous byte-masked write and synchronous read into a registered output. Issue the read one cycle before RESP (in the last WAIT cycle, or at accept when `wait_states`=0).

## Test plan
- Reset, then write 32'hDEADBEEF, mask 4'b1111, to byte 32'h10000010 with wait_states=2 → `mem_ready` 3 cycles after accept, `mem_excpt`=0. A subsequent read of the same address returns 32'hDEADBEEF.
- Write 32'h000000AA with mask 4'b0001 over 32'hDEADBEEF → a read returns 32'hDEADBEAA.
- Read byte 32'h0FFFFFFC and byte 32'h10001000 (one past the end, depth 1024) → `mem_excpt`=1 and `mem_data_out`=0 on both. An out-of-range write leaves the array unchanged.
- New `mem_req` held high through WAIT and RESP → only one `mem_ready`. The next request is accepted in the first IDLE cycle; `mem_busy` is high through WAIT and RESP.
- Assert `rst_b`=0 during WAIT of a write to 32'h10000020 → no `mem_ready`, all outputs 0. A later read of 32'h10000020 returns its prior value.
- wait_states=0: a read accepted at edge N gives `mem_ready` in cycle N+1. Simultaneous `mem_req`=1 and mask 4'b1100 is treated as a write.
